// File: rtl/lcd_touch_mt_scanner.sv
// Multi-point capacitive touch scanner: reads status and point records over the shared
// I2C master command interface, orients the coordinates, and publishes them one frame at a time.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_WAIT    | idle; waiting for INT rising edge or poll tick
//   S_RD_STAT | 1-byte read of the status register
//   S_CHK     | decode ready/count, compute n = min(count, MAX_POINTS)
//   S_RD_PTS  | burst read of 8*n bytes of point records
//   S_CLR     | write 0x00 to the status register to release the frame
//   S_PUBLISH | outputs hold the new frame; frame_upd high for this cycle
module lcd_touch_mt_scanner #(
  parameter int          MAX_POINTS = 5,
  parameter int          H_RES      = 800,
  parameter int          V_RES      = 480,
  parameter int          USE_INT    = 1,
  parameter int          POLL_DIV   = 2500,
  parameter logic [6:0]  SLAVE_ADDR = 7'h14,
  parameter logic [15:0] STAT_REG   = 16'h814E,
  parameter logic [15:0] PT_REG     = 16'h8150,
  parameter bit          SWAP_XY    = 1'b0,
  parameter bit          MIRROR_X   = 1'b0,
  parameter bit          MIRROR_Y   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [6:0]                slave_addr,
  output logic                      i2c_exec,
  output logic                      i2c_rh_wl,
  output logic [15:0]               i2c_addr,
  output logic                      bit_ctrl,
  output logic [7:0]                i2c_data_w,
  output logic [7:0]                reg_num,
  input  logic [7:0]                i2c_data_r,
  input  logic                      once_done,
  input  logic                      i2c_done,
  input  logic                      i2c_ack,
  input  logic                      touch_int_in,
  output logic                      touch_valid,
  output logic [3:0]                point_cnt,
  output logic [MAX_POINTS-1:0]     pt_valid,
  output logic [16*MAX_POINTS-1:0]  pt_x,
  output logic [16*MAX_POINTS-1:0]  pt_y,
  output logic                      frame_upd,
  output logic                      nack_err
);

  localparam int          PW    = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);
  localparam logic [3:0]  NMAX  = 4'(MAX_POINTS);

  typedef enum logic [2:0] {
    S_WAIT, S_RD_STAT, S_CHK, S_RD_PTS, S_CLR, S_PUBLISH
  } state_t;

  state_t          state, state_nxt;
  logic            int_q;
  logic [PW-1:0]   poll_cnt;
  logic            poll_hit, trigger, nack, pub_go;
  logic            stat_rdy;
  logic [3:0]      stat_cnt;
  logic [3:0]      n_q;
  logic [6:0]      k_q;
  logic [15:0]     x_raw [MAX_POINTS];
  logic [15:0]     y_raw [MAX_POINTS];
  logic [15:0]     px    [MAX_POINTS];
  logic [15:0]     py    [MAX_POINTS];

  assign slave_addr = SLAVE_ADDR;
  assign bit_ctrl   = 1'b1;
  assign poll_hit   = (poll_cnt == PW'(POLL_DIV - 1));
  assign trigger    = (USE_INT != 0) ? (touch_int_in & ~int_q) : poll_hit;
  assign nack       = i2c_done & i2c_ack & (state != S_WAIT);
  assign pub_go     = (state == S_CLR) & i2c_done & ~i2c_ack;

  always_comb begin
    state_nxt  = state;
    i2c_rh_wl  = 1'b0;
    i2c_addr   = 16'h0000;
    reg_num    = 8'h00;
    i2c_data_w = 8'h00;
    case (state)
      S_WAIT:    if (trigger) state_nxt = S_RD_STAT;
      S_RD_STAT: begin
        i2c_rh_wl = 1'b1;
        i2c_addr  = STAT_REG;
        reg_num   = 8'd1;
        if (i2c_done) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (!stat_rdy)           state_nxt = S_WAIT;
        else if (stat_cnt == 0)  state_nxt = S_CLR;
        else                     state_nxt = S_RD_PTS;
      end
      S_RD_PTS: begin
        i2c_rh_wl = 1'b1;
        i2c_addr  = PT_REG;
        reg_num   = {1'b0, n_q, 3'b000};
        if (i2c_done) state_nxt = S_CLR;
      end
      S_CLR: begin
        i2c_addr = STAT_REG;
        reg_num  = 8'd1;
        if (i2c_done) state_nxt = S_PUBLISH;
      end
      S_PUBLISH: state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase
    if (nack) state_nxt = S_WAIT;
  end

  // Orientation order matters: clamp first so mirroring never underflows.
  always_comb begin
    logic [15:0] xc, yc;
    for (int i = 0; i < MAX_POINTS; i++) begin
      xc = (x_raw[i] > X_MAX) ? X_MAX : x_raw[i];
      yc = (y_raw[i] > Y_MAX) ? Y_MAX : y_raw[i];
      if (MIRROR_X) xc = X_MAX - xc;
      if (MIRROR_Y) yc = Y_MAX - yc;
      px[i] = SWAP_XY ? yc : xc;
      py[i] = SWAP_XY ? xc : yc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_WAIT;
      int_q       <= 1'b0;
      poll_cnt    <= '0;
      i2c_exec    <= 1'b0;
      nack_err    <= 1'b0;
      frame_upd   <= 1'b0;
      stat_rdy    <= 1'b0;
      stat_cnt    <= 4'd0;
      n_q         <= 4'd0;
      k_q         <= 7'd0;
      touch_valid <= 1'b0;
      point_cnt   <= 4'd0;
      pt_valid    <= '0;
      pt_x        <= '0;
      pt_y        <= '0;
      for (int i = 0; i < MAX_POINTS; i++) begin
        x_raw[i] <= 16'h0000;
        y_raw[i] <= 16'h0000;
      end
    end else begin
      state     <= state_nxt;
      int_q     <= touch_int_in;
      poll_cnt  <= poll_hit ? '0 : poll_cnt + 1'b1;
      i2c_exec  <= (state_nxt != state) &&
                   (state_nxt == S_RD_STAT || state_nxt == S_RD_PTS || state_nxt == S_CLR);
      nack_err  <= nack;
      frame_upd <= pub_go;
      if (state == S_RD_STAT && once_done) begin
        stat_rdy <= i2c_data_r[7];
        stat_cnt <= i2c_data_r[3:0];
      end
      if (state == S_CHK) begin
        n_q <= (stat_cnt > NMAX) ? NMAX : stat_cnt;
        k_q <= 7'd0;
      end
      // Record layout per point: id, xL, xH, yL, yH, then 3 ignored bytes.
      if (state == S_RD_PTS && once_done) begin
        k_q <= k_q + 7'd1;
        for (int i = 0; i < MAX_POINTS; i++) begin
          if (k_q[6:3] == 4'(i)) begin
            case (k_q[2:0])
              3'd1:    x_raw[i][7:0]  <= i2c_data_r;
              3'd2:    x_raw[i][15:8] <= i2c_data_r;
              3'd3:    y_raw[i][7:0]  <= i2c_data_r;
              3'd4:    y_raw[i][15:8] <= i2c_data_r;
              default: ;
            endcase
          end
        end
      end
      if (pub_go) begin
        point_cnt   <= n_q;
        touch_valid <= (n_q != 4'd0);
        for (int i = 0; i < MAX_POINTS; i++) begin
          pt_valid[i]      <= (4'(i) < n_q);
          pt_x[16*i +: 16] <= (4'(i) < n_q) ? px[i] : 16'h0000;
          pt_y[16*i +: 16] <= (4'(i) < n_q) ? py[i] : 16'h0000;
        end
      end
    end
  end

endmodule
